// File: rtl/mux_arb_nt1.sv
// N-to-1 registered multiplexer with per-channel valid/ready handshakes.
// Selects one channel per cycle by explicit index or by round-robin arbitration.
module mux_arb_nt1 #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  osel_q, osel_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic             valid_q, valid_d;

    logic             load;
    logic             grant;
    logic [SELW-1:0]  gidx;
    logic [N-1:0]     gnt_oh;
    logic [WIDTH-1:0] gdata;

    always_comb begin
        load   = !valid_q || out_ready;
        grant  = 1'b0;
        gidx   = '0;
        gnt_oh = '0;
        gdata  = '0;
        if (load) begin
            if (!mode) begin
                // Indices at or above N never match, so an out-of-range sel grants nothing.
                for (int unsigned i = 0; i < N; i++) begin
                    if (32'(sel) == i && in_valid[i]) begin
                        grant     = 1'b1;
                        gidx      = SELW'(i);
                        gnt_oh[i] = 1'b1;
                        gdata     = in_data[i*WIDTH +: WIDTH];
                    end
                end
            end else begin
                // Rotating priority as two linear scans: ptr..N-1, then 0..ptr-1.
                for (int unsigned i = 0; i < N; i++) begin
                    if (!grant && i >= 32'(ptr_q) && in_valid[i]) begin
                        grant     = 1'b1;
                        gidx      = SELW'(i);
                        gnt_oh[i] = 1'b1;
                        gdata     = in_data[i*WIDTH +: WIDTH];
                    end
                end
                for (int unsigned i = 0; i < N; i++) begin
                    if (!grant && i < 32'(ptr_q) && in_valid[i]) begin
                        grant     = 1'b1;
                        gidx      = SELW'(i);
                        gnt_oh[i] = 1'b1;
                        gdata     = in_data[i*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        osel_d  = osel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = grant;
            if (grant) begin
                data_d = gdata;
                osel_d = gidx;
                if (mode) begin
                    ptr_d = (gidx == SELW'(N - 1)) ? '0 : gidx + SELW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            osel_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            osel_q  <= osel_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

    // No acceptance is signalled while reset is asserted, so nothing is lost at the edge.
    assign in_ready  = rst ? '0 : gnt_oh;
    assign out_data  = data_q;
    assign out_sel   = osel_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_arb_nt1.sv
// Directed bench for mux_arb_nt1 (N=8/W=32 and N=5/W=12) with a reference grant model
// and an expected-word queue checked against the output register.
module tb_mux_arb_nt1;

    logic        clk = 1'b0;
    logic        rst;

    logic        mode8, out_ready8, out_valid8;
    logic [2:0]  sel8, out_sel8;
    logic [255:0] in_data8;
    logic [7:0]  in_valid8, in_ready8;
    logic [31:0] out_data8;

    logic        mode5, out_ready5, out_valid5;
    logic [2:0]  sel5, out_sel5;
    logic [59:0] in_data5;
    logic [4:0]  in_valid5, in_ready5;
    logic [11:0] out_data5;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  s;
    } exp_t;
    exp_t        q[$];
    logic [31:0] dval[8];
    bit          m_ov;
    int          m_ptr;

    always #5 clk = ~clk;

    mux_arb_nt1 #(.WIDTH(32), .N(8)) dut8 (
        .clk(clk), .rst(rst), .mode(mode8), .sel(sel8),
        .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
        .out_data(out_data8), .out_sel(out_sel8), .out_valid(out_valid8),
        .out_ready(out_ready8)
    );

    mux_arb_nt1 #(.WIDTH(12), .N(5)) dut5 (
        .clk(clk), .rst(rst), .mode(mode5), .sel(sel5),
        .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
        .out_data(out_data5), .out_sel(out_sel5), .out_valid(out_valid5),
        .out_ready(out_ready5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_data(input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            dval[i] = base + 32'(i);
            in_data8[i*32 +: 32] = dval[i];
        end
    endtask

    // Called at posedge+1: drives one cycle, checks in_ready at negedge, output after the edge.
    task automatic cyc(input string tag, input bit md, input int s, input logic [7:0] v, input bit ordy);
        int          g;
        bit          ld;
        logic [7:0]  exp_rdy;
        mode8 = md; sel8 = 3'(s); in_valid8 = v; out_ready8 = ordy;
        #4;
        ld = !m_ov || ordy;
        g  = -1;
        if (ld) begin
            if (!md) begin
                if (s < 8 && v[s]) g = s;
            end else begin
                for (int k = 0; k < 8; k++)
                    if (g < 0 && v[(m_ptr + k) % 8]) g = (m_ptr + k) % 8;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk({tag, ".in_ready"}, 32'(in_ready8), 32'(exp_rdy));
        if (m_ov && ordy) void'(q.pop_front());
        if (g >= 0) begin
            q.push_back('{dval[g], 3'(g)});
            m_ov = 1'b1;
            if (md) m_ptr = (g + 1) % 8;
        end else if (ld) begin
            m_ov = 1'b0;
        end
        @(posedge clk); #1;
        chk({tag, ".out_valid"}, 32'(out_valid8), 32'(m_ov));
        if (m_ov && q.size() > 0) begin
            chk({tag, ".out_data"}, out_data8, q[0].d);
            chk({tag, ".out_sel"}, 32'(out_sel8), 32'(q[0].s));
        end
    endtask

    initial begin
        rst = 1'b1;
        mode8 = 1'b1; sel8 = '0; in_valid8 = 8'hFF; out_ready8 = 1'b1;
        mode5 = 1'b0; sel5 = '0; in_valid5 = '0; out_ready5 = 1'b1;
        load_data(32'h0);
        for (int i = 0; i < 5; i++) in_data5[i*12 +: 12] = 12'h0A0 + 12'(i);
        m_ov = 1'b0; m_ptr = 0;

        #2;
        chk("rst.out_valid", 32'(out_valid8), 32'd0);
        chk("rst.out_data", out_data8, 32'd0);
        chk("rst.out_sel", 32'(out_sel8), 32'd0);
        chk("rst.in_ready", 32'(in_ready8), 32'd0);
        in_valid8 = '0; mode8 = 1'b0;
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // N=5: round-robin wrap, then out-of-range select.
        mode5 = 1'b1; in_valid5 = '1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("n5.rr.out_valid", 32'(out_valid5), 32'd1);
            chk("n5.rr.out_sel", 32'(out_sel5), 32'(k % 5));
            chk("n5.rr.out_data", 32'(out_data5), 32'h0A0 + 32'(k % 5));
        end
        mode5 = 1'b0; sel5 = 3'd6;
        #4;
        chk("n5.sel6.in_ready", 32'(in_ready5), 32'd0);
        @(posedge clk); #1;
        chk("n5.sel6.out_valid", 32'(out_valid5), 32'd0);
        in_valid5 = '0;

        // Fixed select.
        cyc("fix5", 0, 5, 8'hFF, 1'b1);
        cyc("fix5b", 0, 5, 8'hFF, 1'b1);
        cyc("fix2", 0, 2, 8'hFF, 1'b1);
        cyc("fix3inv", 0, 3, 8'hF7, 1'b1);

        // Round-robin fairness, then sparse valids.
        for (int k = 0; k < 10; k++) cyc("rr_all", 1, 0, 8'hFF, 1'b1);
        for (int k = 0; k < 4; k++) cyc("rr_sparse", 1, 0, 8'h84, 1'b1);

        // Backpressure with fresh data so stale words are distinguishable.
        load_data(32'h100);
        for (int k = 0; k < 3; k++) cyc("bp_hold", 1, 0, 8'hFF, 1'b0);
        for (int k = 0; k < 3; k++) cyc("bp_drain", 1, 0, 8'hFF, 1'b1);

        // Mode 1 -> 0 -> 1 keeps the pointer.
        cyc("mode0_mid", 0, 1, 8'hFF, 1'b1);
        cyc("mode1_resume", 1, 0, 8'hFF, 1'b1);
        cyc("mode1_resume2", 1, 0, 8'hFF, 1'b1);

        // Load a word and hold it, then reset asynchronously mid-cycle.
        cyc("pre_rst", 1, 0, 8'hFF, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst.out_valid", 32'(out_valid8), 32'd0);
        chk("arst.out_data", out_data8, 32'd0);
        chk("arst.out_sel", 32'(out_sel8), 32'd0);
        chk("arst.in_ready", 32'(in_ready8), 32'd0);
        q.delete(); m_ov = 1'b0; m_ptr = 0;
        @(posedge clk); #1;
        chk("arst.in_ready_held", 32'(in_ready8), 32'd0);
        in_valid8 = '0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        cyc("post_rst", 1, 0, 8'h18, 1'b1);
        cyc("post_rst2", 1, 0, 8'h18, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_arb_nt1.md
# mux_arb_nt1

Parametrised N-to-1, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes. It selects one input channel per cycle, either by an explicit select (fixed mode) or by round-robin arbitration, and registers the chosen word into a single output stage. It supersedes the fixed 8-channel, 32-bit combinational multiplexer for datapaths that need flow control and fair sharing of one sink among several sources.

## Interface

Parameters:
- WIDTH, 32, data width per channel
- N, 8, channel count (2..16, need not be a power of two)
- SELW, $clog2(N), select/index width (derived localparam, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock, reset asynchronous and active-high
- mode  in  1  0 = fixed select by `sel`, 1 = round-robin
- sel  in  SELW  channel index used in fixed mode
- in_data  in  N*WIDTH  flattened inputs; channel i at [i*WIDTH +: WIDTH]
- in_valid  in  N  per-channel valid
- in_ready  out  N  per-channel ready (one-hot or zero)
- out_data  out  WIDTH  registered output word
- out_sel  out  SELW  index of channel that supplied out_data
- out_valid  out  1  output register holds a word
- out_ready  in  1  sink accepts output word

## Operation

- State: output register (out_data, out_sel, out_valid), round-robin pointer ptr (SELW bits, range 0..N-1).
- load = !out_valid || out_ready. Arbitration is evaluated only when load=1; otherwise in_ready = 0.
- Grant, mode 0: g = sel if sel < N and in_valid[sel]; else no grant.
- Grant, mode 1: g = first index i in ptr, ptr+1, …, N-1, 0, …, ptr-1 with in_valid[i]; none if in_valid = 0.
- On grant (load=1): in_ready[g] = 1 combinationally; at edge out_data <= in_data[g], out_sel <= g, out_valid <= 1; in mode 1, ptr <= (g == N-1) ? 0 : g+1.
- No grant with load=1: out_valid <= 0; out_data and out_sel hold.
- ptr never changes in mode 0; after mode 1→0→1 round-robin resumes from retained ptr.
- Transfer on an input occurs when in_valid[i] && in_ready[i]; on output when out_valid && out_ready.
- While out_valid && !out_ready: out_data, out_sel, out_valid stable; all in_ready = 0.
- in_ready depends combinationally on in_valid, mode, sel, ptr, out_valid, out_ready. Sources must not derive in_valid from in_ready.
- sel ≥ N (non-power-of-two N) yields no grant, never an X read.

## Timing

- Reset (async assert, sync release): out_valid = 0, out_data = 0, out_sel = 0, ptr = 0; in_ready = 0 while rst high.
- Reset mid-transfer: held word is dropped, no in_ready pulse is issued in the reset cycle.
- Latency: input accepted in cycle t appears on out_data with out_valid = 1 from cycle t+1.
- Throughput: one word per cycle when out_ready held high (accept and drain in the same cycle).
- mode/sel changes take effect in the same cycle's arbitration; word already in output register unaffected.
- ptr wrap: g = N-1 sets ptr = 0.

## Test plan

- Reset mid-stream: rst pulsed asynchronously (not edge-aligned) while out_valid = 1 -> out_valid, out_data, out_sel go 0 immediately; in_ready = 0 during rst; first post-reset grant in mode 1 is lowest valid index ≥ 0.
- Fixed select: mode 0, in_data channel i = i, all valid, sel = 5, out_ready = 1 -> in_ready = 8'b0010_0000, next cycle out_data = 5, out_sel = 5; sel = 2 -> out_data = 2 one cycle later.
- Fixed select, invalid channel: mode 0, sel = 3, in_valid[3] = 0, others 1 -> in_ready = 0, out_valid = 0 after one cycle.
- Round-robin fairness: mode 1, all valid, out_ready = 1 for 10 cycles -> out_sel sequence 0,1,2,…,7,0,1; sparse in_valid = 8'b1000_0100 -> grants alternate 2,7,2,7.
- Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 -> out_data/out_sel constant, in_ready = 0, ptr unchanged; out_ready = 1 -> held word drained and next grant loaded same cycle, no word lost or duplicated (scoreboard per channel).
- N = 5, WIDTH = 12: mode 1 all valid -> out_sel 0,1,2,3,4,0 (wrap); mode 0 sel = 6 -> no grant, out_valid = 0.
